// File: rtl/instr_type.sv
// Store instruction types shared by the store issue path.
// Kind/error enums plus decode and size helpers.
package instr_type;

    typedef enum logic [2:0] {
        sk_sb      = 3'd0,
        sk_sh      = 3'd1,
        sk_sw      = 3'd2,
        sk_invalid = 3'd3,
        sk_sd      = 3'd4
    } store_kind_t;

    typedef enum logic [1:0] {
        se_none       = 2'd0,
        se_invalid    = 2'd1,
        se_misaligned = 2'd2
    } store_err_t;

    // Byte count of a store kind; 0 for invalid.
    function automatic logic [3:0] store_size(store_kind_t k);
        logic [3:0] s;
        s = 4'd0;
        unique case (k)
            sk_sb:   s = 4'd1;
            sk_sh:   s = 4'd2;
            sk_sw:   s = 4'd4;
            sk_sd:   s = 4'd8;
            default: s = 4'd0;
        endcase
        return s;
    endfunction

    // funct3 to kind; sd only exists on a 64-bit datapath.
    function automatic store_kind_t store_decode(
        logic [2:0] funct3,
        logic       wide
    );
        store_kind_t k;
        k = sk_invalid;
        unique case (funct3)
            3'b000:  k = sk_sb;
            3'b001:  k = sk_sh;
            3'b010:  k = sk_sw;
            3'b011:  k = wide ? sk_sd : sk_invalid;
            default: k = sk_invalid;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request, bus and response bundle of the store unit.
// master drives requests and bus_ready; slave is the unit.
interface store_unit_if
    import instr_type::*;
#(
    parameter int XLEN = 32
);

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_funct3;
    logic [XLEN-1:0]     req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic                bus_valid;
    logic                bus_ready;
    logic [XLEN-1:0]     bus_addr;
    logic [XLEN-1:0]     bus_wdata;
    logic [XLEN/8-1:0]   bus_wstrb;
    logic                resp_valid;
    store_err_t          resp_err;
    store_kind_t         kind;

    modport master (
        output req_valid, req_funct3, req_addr, req_wdata, bus_ready,
        input  req_ready, bus_valid, bus_addr, bus_wdata, bus_wstrb,
        input  resp_valid, resp_err, kind
    );

    modport slave (
        input  req_valid, req_funct3, req_addr, req_wdata, bus_ready,
        output req_ready, bus_valid, bus_addr, bus_wdata, bus_wstrb,
        output resp_valid, resp_err, kind
    );

endinterface

// File: rtl/store_lane_align.sv
// Places store data onto bus byte lanes across two words.
// Purely combinational; also flags misalignment and crossing.
module store_lane_align
    import instr_type::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  store_kind_t     kind,
    input  logic [OW-1:0]   offset,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] wdata0,
    output logic [XLEN-1:0] wdata1,
    output logic [NB-1:0]   wstrb0,
    output logic [NB-1:0]   wstrb1,
    output logic            misaligned,
    output logic            crossing
);

    logic [3:0]        size;
    logic [OW-1:0]     lsb;
    logic [XLEN-1:0]   masked;
    logic [NB-1:0]     smask;
    logic [2*XLEN-1:0] wide;
    logic [2*NB-1:0]   swide;

    // Mask to the store size, then shift into a two-word window.
    always_comb begin
        size   = store_size(kind);
        masked = '0;
        smask  = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < int'(size)) begin
                masked[b*8 +: 8] = data[b*8 +: 8];
                smask[b]         = 1'b1;
            end
        end
        wide       = {{XLEN{1'b0}}, masked} << {offset, 3'b000};
        swide      = {{NB{1'b0}}, smask} << offset;
        lsb        = OW'(size - 4'd1);
        misaligned = |(offset & lsb);
        crossing   = (int'(offset) + int'(size)) > NB;
        wdata0     = wide[XLEN-1:0];
        wdata1     = wide[2*XLEN-1:XLEN];
        wstrb0     = swide[NB-1:0];
        wstrb1     = swide[2*NB-1:NB];
    end

endmodule

// File: rtl/store_unit.sv
// Store issue unit: decode, lane-align and split stores into beats.
// Every accepted request ends with a one-cycle response.
module store_unit
    import instr_type::*;
#(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    store_unit_if.slave sif
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    store_kind_t     dec_kind;
    logic            accept;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] al_wdata0;
    logic [XLEN-1:0] al_wdata1;
    logic [NB-1:0]   al_wstrb0;
    logic [NB-1:0]   al_wstrb1;
    logic            al_mis;
    logic            al_cross;
    logic [XLEN-1:0] b1_addr;
    logic [XLEN-1:0] b1_wdata;
    logic [NB-1:0]   b1_wstrb;
    logic            cross_q;

    assign dec_kind = store_decode(sif.req_funct3, XLEN == 64);
    assign accept   = sif.req_valid && sif.req_ready;
    assign base     = {sif.req_addr[XLEN-1:OW], {OW{1'b0}}};

    store_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .kind       (dec_kind),
        .offset     (sif.req_addr[OW-1:0]),
        .data       (sif.req_wdata),
        .wdata0     (al_wdata0),
        .wdata1     (al_wdata1),
        .wstrb0     (al_wstrb0),
        .wstrb1     (al_wstrb1),
        .misaligned (al_mis),
        .crossing   (al_cross)
    );

    // Request FSM; beat1 is captured at acceptance so req_* may change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            sif.req_ready  <= 1'b1;
            sif.bus_valid  <= 1'b0;
            sif.bus_addr   <= '0;
            sif.bus_wdata  <= '0;
            sif.bus_wstrb  <= '0;
            sif.resp_valid <= 1'b0;
            sif.resp_err   <= se_none;
            sif.kind       <= sk_invalid;
            b1_addr        <= '0;
            b1_wdata       <= '0;
            b1_wstrb       <= '0;
            cross_q        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sif.req_ready <= 1'b0;
                        sif.kind      <= dec_kind;
                        if (dec_kind == sk_invalid) begin
                            sif.resp_valid <= 1'b1;
                            sif.resp_err   <= se_invalid;
                            state          <= RESP;
                        end else if (al_mis && !SPLIT_MISALIGNED) begin
                            sif.resp_valid <= 1'b1;
                            sif.resp_err   <= se_misaligned;
                            state          <= RESP;
                        end else begin
                            sif.bus_valid <= 1'b1;
                            sif.bus_addr  <= base;
                            sif.bus_wdata <= al_wdata0;
                            sif.bus_wstrb <= al_wstrb0;
                            b1_addr       <= base + XLEN'(NB);
                            b1_wdata      <= al_wdata1;
                            b1_wstrb      <= al_wstrb1;
                            cross_q       <= al_cross;
                            state         <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (sif.bus_ready) begin
                        if (cross_q) begin
                            sif.bus_addr  <= b1_addr;
                            sif.bus_wdata <= b1_wdata;
                            sif.bus_wstrb <= b1_wstrb;
                            state         <= BEAT1;
                        end else begin
                            sif.bus_valid  <= 1'b0;
                            sif.resp_valid <= 1'b1;
                            sif.resp_err   <= se_none;
                            state          <= RESP;
                        end
                    end
                end
                BEAT1: begin
                    if (sif.bus_ready) begin
                        sif.bus_valid  <= 1'b0;
                        sif.resp_valid <= 1'b1;
                        sif.resp_err   <= se_none;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    sif.resp_valid <= 1'b0;
                    sif.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: three instances (32/split, 32/no-split, 64).
// Directed plan cases plus random stores against a byte-level model.
module tb_store_unit;
    import instr_type::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  rv;
    logic [2:0]  bready;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;

    logic [2:0]  rr;
    logic [2:0]  bv;
    logic [2:0]  rsp;
    logic [63:0] ba [3];
    logic [63:0] bw [3];
    logic [7:0]  bs [3];
    store_err_t  er [3];
    store_kind_t kd [3];

    always #5 clk = ~clk;

    store_unit_if #(.XLEN(32)) i0 ();
    store_unit_if #(.XLEN(32)) i1 ();
    store_unit_if #(.XLEN(64)) i2 ();

    store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut0 (
        .clk (clk), .rst (rst), .sif (i0.slave));
    store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut1 (
        .clk (clk), .rst (rst), .sif (i1.slave));
    store_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) dut2 (
        .clk (clk), .rst (rst), .sif (i2.slave));

    assign i0.req_valid  = rv[0];
    assign i1.req_valid  = rv[1];
    assign i2.req_valid  = rv[2];
    assign i0.bus_ready  = bready[0];
    assign i1.bus_ready  = bready[1];
    assign i2.bus_ready  = bready[2];
    assign i0.req_funct3 = f3;
    assign i1.req_funct3 = f3;
    assign i2.req_funct3 = f3;
    assign i0.req_addr   = addr[31:0];
    assign i1.req_addr   = addr[31:0];
    assign i2.req_addr   = addr;
    assign i0.req_wdata  = wdata[31:0];
    assign i1.req_wdata  = wdata[31:0];
    assign i2.req_wdata  = wdata;

    assign rr  = {i2.req_ready, i1.req_ready, i0.req_ready};
    assign bv  = {i2.bus_valid, i1.bus_valid, i0.bus_valid};
    assign rsp = {i2.resp_valid, i1.resp_valid, i0.resp_valid};
    assign ba[0] = 64'(i0.bus_addr);
    assign ba[1] = 64'(i1.bus_addr);
    assign ba[2] = i2.bus_addr;
    assign bw[0] = 64'(i0.bus_wdata);
    assign bw[1] = 64'(i1.bus_wdata);
    assign bw[2] = i2.bus_wdata;
    assign bs[0] = 8'(i0.bus_wstrb);
    assign bs[1] = 8'(i1.bus_wstrb);
    assign bs[2] = i2.bus_wstrb;
    assign er[0] = i0.resp_err;
    assign er[1] = i1.resp_err;
    assign er[2] = i2.resp_err;
    assign kd[0] = i0.kind;
    assign kd[1] = i1.kind;
    assign kd[2] = i2.kind;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One store on instance w; model builds beats byte by byte.
    task automatic do_store(input int w, input logic [2:0] fn,
                            input logic [63:0] a, input logic [63:0] d,
                            input int stall_first, input int pct);
        int          xl, nb, sz, n, bi, cyc, stalls, nresp;
        bit          split, held;
        store_kind_t ek;
        store_err_t  ee;
        logic [63:0] ea [2];
        logic [63:0] ed [2];
        logic [7:0]  es [2];
        logic [63:0] pa, pd;
        logic [7:0]  ps;

        xl    = (w == 2) ? 64 : 32;
        nb    = xl / 8;
        split = (w != 1);
        if (xl == 32) a = {32'b0, a[31:0]};
        case (fn)
            3'd0:    begin sz = 1; ek = sk_sb; end
            3'd1:    begin sz = 2; ek = sk_sh; end
            3'd2:    begin sz = 4; ek = sk_sw; end
            3'd3:    begin
                sz = (xl == 64) ? 8 : 0;
                ek = (xl == 64) ? sk_sd : sk_invalid;
            end
            default: begin sz = 0; ek = sk_invalid; end
        endcase
        n = 0;
        ea[0] = '0; ea[1] = '0; ed[0] = '0; ed[1] = '0;
        es[0] = '0; es[1] = '0;
        if (sz == 0) begin
            ee = se_invalid;
        end else if ((a % 64'(sz)) != 0 && !split) begin
            ee = se_misaligned;
        end else begin
            ee = se_none;
            for (int i = 0; i < sz; i++) begin
                logic [63:0] bx, word;
                int          lane;
                bx   = a + 64'(i);
                word = bx - (bx % 64'(nb));
                lane = int'(bx % 64'(nb));
                if (n == 0 || word != ea[n-1]) begin
                    ea[n] = word;
                    n++;
                end
                ed[n-1][lane*8 +: 8] = d[i*8 +: 8];
                es[n-1][lane]        = 1'b1;
            end
        end

        @(negedge clk);
        chk("idle_ready", 64'(rr[w]), 64'd1);
        f3        = fn;
        addr      = a;
        wdata     = d;
        bready[w] = 1'b1;
        rv[w]     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv[w] = 1'b0;
        f3    = 3'($urandom);
        addr  = {$urandom, $urandom};
        wdata = {$urandom, $urandom};
        chk("kind", 64'(kd[w]), 64'(ek));

        cyc = 1; bi = 0; stalls = 0; nresp = 0; held = 1'b0;
        pa = '0; pd = '0; ps = '0;
        while (cyc < 40 && nresp == 0) begin
            chk("busy_ready", 64'(rr[w]), 64'd0);
            if (bv[w]) begin
                if (held) begin
                    chk("hold_addr", ba[w], pa);
                    chk("hold_data", bw[w], pd);
                    chk("hold_strb", 64'(bs[w]), 64'(ps));
                end
                if (bi < n) begin
                    chk("beat_addr", ba[w], ea[bi]);
                    chk("beat_data", bw[w], ed[bi]);
                    chk("beat_strb", 64'(bs[w]), 64'(es[bi]));
                end else begin
                    chk("extra_beat", 64'(bi), 64'(n));
                end
                if (stall_first > 0) begin
                    bready[w] = 1'b0;
                    stall_first--;
                end else begin
                    bready[w] = ($urandom_range(99) >= pct);
                end
                held = !bready[w];
                pa = ba[w]; pd = bw[w]; ps = bs[w];
                if (bready[w]) bi++;
                else stalls++;
            end else begin
                held = 1'b0;
            end
            if (rsp[w]) begin
                nresp++;
                chk("resp_err", 64'(er[w]), 64'(ee));
                chk("beats_done", 64'(bi), 64'(n));
                chk("resp_cycle", 64'(cyc),
                    64'((n == 0) ? 1 : 1 + n + stalls));
            end
            @(negedge clk);
            cyc++;
        end
        chk("resp_seen", 64'(nresp), 64'd1);
        bready[w] = 1'b1;
        chk("resp_pulse", 64'(rsp[w]), 64'd0);
        chk("ready_back", 64'(rr[w]), 64'd1);
        chk("bus_idle", 64'(bv[w]), 64'd0);
    endtask

    initial begin
        rv     = '0;
        bready = 3'b111;
        f3     = '0;
        addr   = '0;
        wdata  = '0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            chk("rst_bv", 64'(bv[w]), 64'd0);
            chk("rst_rsp", 64'(rsp[w]), 64'd0);
            chk("rst_addr", ba[w], 64'd0);
            chk("rst_data", bw[w], 64'd0);
            chk("rst_strb", 64'(bs[w]), 64'd0);
            chk("rst_err", 64'(er[w]), 64'(se_none));
            chk("rst_kind", 64'(kd[w]), 64'(sk_invalid));
        end
        rst = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 3; w++) chk("rel_ready", 64'(rr[w]), 64'd1);

        // Single-beat byte store.
        do_store(0, 3'b000, 64'h1002, 64'h0000_00AB, 0, 0);
        // Word store crossing a bus word.
        do_store(0, 3'b010, 64'h1003, 64'hAABB_CCDD, 0, 0);
        // No-split instance: rejected and aligned halfwords.
        do_store(1, 3'b001, 64'h1001, 64'h1234, 0, 0);
        do_store(1, 3'b001, 64'h1002, 64'h1234, 0, 0);
        // Invalid kinds and the 64-bit doubleword.
        do_store(0, 3'b011, 64'h1000, 64'h55, 0, 0);
        for (int k = 4; k < 8; k++)
            do_store(2, 3'(k), 64'h20, 64'h77, 0, 0);
        do_store(2, 3'b011, 64'h10, 64'h0123_4567_89AB_CDEF, 0, 0);
        // Five-cycle stall on beat0.
        do_store(0, 3'b010, 64'h1004, 64'hCAFE_F00D, 5, 0);
        do_store(2, 3'b011, 64'h13, 64'h1122_3344_5566_7788, 5, 0);

        // Asynchronous reset while a beat is stalled.
        @(negedge clk);
        f3 = 3'b010; addr = 64'h2000; wdata = 64'h9999;
        bready[0] = 1'b0;
        rv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv[0] = 1'b0;
        chk("pre_rst_bv", 64'(bv[0]), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_bv", 64'(bv[0]), 64'd0);
        chk("async_rsp", 64'(rsp[0]), 64'd0);
        chk("async_addr", ba[0], 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(rsp[0]), 64'd0);
        end
        rst = 1'b1;
        bready[0] = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(rr[0]), 64'd1);
        chk("post_rst_rsp", 64'(rsp[0]), 64'd0);
        chk("post_rst_bv", 64'(bv[0]), 64'd0);

        // Random stores with random back-pressure.
        for (int t = 0; t < 60; t++) begin
            int          w;
            logic [2:0]  fn;
            logic [63:0] a;
            w  = $urandom_range(2);
            fn = ($urandom_range(3) != 0) ? 3'($urandom_range(3))
                                          : 3'($urandom_range(7));
            a  = {$urandom, $urandom};
            a[63:60] = 4'h0;
            do_store(w, fn, a, {$urandom, $urandom}, 0, 30);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Parametrised store issue unit between the decode stage and the data-memory bus. Accepts one store request (funct3, byte address, register data) per valid/ready handshake. Classifies the store width, generates lane-aligned write data and byte strobes for an XLEN-wide bus, and splits word-crossing stores into two bus beats. Finishes every request with a one-cycle response carrying an error cause.

## Interface
Parameters:
- XLEN, 32, bus and register width; legal values 32 or 64.
- SPLIT_MISALIGNED, 1, 1: misaligned stores are executed (split if they cross a bus word); 0: any misaligned store is rejected with se_misaligned.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_funct3  in  3  store funct3.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- bus_valid  out  1  beat present.
- bus_ready  in  1  bus accepts beat.
- bus_addr  out  XLEN  beat address, aligned to XLEN/8.
- bus_wdata  out  XLEN  lane-aligned data; unused lanes 0.
- bus_wstrb  out  XLEN/8  byte enables.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  store_err_t  se_none / se_invalid / se_misaligned.
- kind  out  store_kind_t  kind of the most recently accepted request.

## Operation
- Decode: 000→sk_sb (1 B), 001→sk_sh (2 B), 010→sk_sw (4 B), 011→sk_sd (8 B) only if XLEN=64, else sk_invalid; 100–111→sk_invalid.
- Field widths: offset = addr[log2(XLEN/8)-1:0]; misaligned = offset not a multiple of size; crossing = offset+size > XLEN/8.
- Alignment: form the 2·XLEN-bit value req_wdata[size·8-1:0] << (offset·8), together with strobe ((1<<size)-1) << offset.
- Beat0 takes the low half: addr = req_addr with offset cleared.
- Beat1 (crossing only) takes the high half: addr = beat0 addr + XLEN/8.
- All request fields are latched on acceptance. Later changes to the req_* inputs have no effect.
- States:
  - IDLE: on req_valid&&req_ready, latch the request and update kind. Then go to RESP with se_invalid if kind=sk_invalid. Else go to RESP with se_misaligned if misaligned and SPLIT_MISALIGNED=0. Else go to BEAT0.
  - BEAT0: bus_valid=1. On bus_ready, go to BEAT1 if crossing, else go to RESP with se_none.
  - BEAT1: bus_valid=1. On bus_ready, go to RESP with se_none.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Rejected requests never assert bus_valid.

## Timing
- All outputs are registered.
- Reset values: state IDLE; req_ready=1 after reset release; bus_valid=0; bus_addr/bus_wdata/bus_wstrb=0; resp_valid=0; resp_err=se_none; kind=sk_invalid.
- Latency for a single beat with bus_ready tied high:
  - Acceptance edge at cycle 0.
  - bus_valid during cycle 1.
  - resp_valid during cycle 2.
  - req_ready high again in cycle 3.
- A crossing store adds one cycle.
- A rejected request gives resp_valid in cycle 1.
- While bus_valid && !bus_ready, bus_addr, bus_wdata and bus_wstrb hold stable. Stalls of any length are legal.
- Beat0 to beat1 transition: on the beat0 handshake edge the outputs switch directly to beat1 values, and bus_valid stays high with no bubble.
- An asynchronous reset during any state returns the unit to IDLE immediately and clears all outputs. An in-flight beat is abandoned and no response is produced.

## Structure
- Package instr_type:
  - Extend store_kind_t with sk_sd; keep existing encodings.
  - Add store_err_t {se_none, se_invalid, se_misaligned}.
  - Add function store_size(store_kind_t) returning the byte count.
- Sub-module store_lane_align: purely combinational. Takes XLEN; inputs kind, offset and data; outputs the beat0/beat1 wdata, the beat0/beat1 wstrb, misaligned and crossing.
- store_unit holds the FSM and all registers.

## Test plan
- XLEN=32, SB at 0x1002 with data 0x000000AB, bus_ready=1:
  - One beat: addr 0x1000, wdata 0x00AB0000, wstrb 0100.
  - resp_err=se_none two cycles after acceptance.
- XLEN=32, SPLIT=1, SW at 0x1003 with data 0xAABBCCDD:
  - Beat0: addr 0x1000, wdata 0xDD000000, wstrb 1000.
  - Beat1: addr 0x1004, wdata 0x00AABBCC, wstrb 0111.
  - Exactly one resp_valid.
- XLEN=32, SPLIT=0:
  - SH at 0x1001 → no bus_valid; resp_err=se_misaligned in the cycle after acceptance.
  - SH at 0x1002 → one beat with wstrb 1100.
- Invalid kinds:
  - funct3 011 on XLEN=32 → kind=sk_invalid, resp_err=se_invalid.
  - funct3 100–111 on XLEN=64 → kind=sk_invalid, resp_err=se_invalid.
  - funct3 011 at 0x10 on XLEN=64 → one beat with wstrb 0xFF, no error.
- Back-pressure and reset:
  - Hold bus_ready=0 for 5 cycles during beat0 → bus outputs stable and req_ready=0 throughout.
  - Assert rst mid-beat → bus_valid drops asynchronously, no resp_valid, req_ready=1 after release.
